serial_addsub: RTL

//  Multi-cycle, parametrised adder/subtractor built from a chain of CHUNK full-adder cells.
//  - Each cycle it adds one CHUNK-bit slice of the operands and keeps the carry in a register between slices.
//  - Trades latency for area in the datapath, for wide operands where a full WIDTH-bit ripple chain misses timing.
//  - Adds subtract mode, signed-overflow detection and a start/busy/done handshake; the single-bit full adder has none of these.

---
 rtl/serial_addsub.sv | 130 +++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle through a ripple
// chain of full-adder cells, carry held in a register between slices.

module serial_addsub_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("serial_addsub: illegal WIDTH/CHUNK combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [CHUNK:0]   cc;
  logic [CHUNK-1:0] ss;
  logic             accept, last;

  // Operands shift right each cycle, so the active slice is always the low CHUNK bits.
  assign cc[0] = carry;
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
      serial_addsub_fa u_fa (
        .x (a_q[gi]),
        .y (b_q[gi]),
        .ci(cc[gi]),
        .s (ss[gi]),
        .co(cc[gi+1])
      );
    end
  endgenerate

  // Partial results accumulate MSB-first into a shift register; after N
  // slices the first slice has reached the bottom.
  always_comb begin
    acc_nxt                   = acc >> CHUNK;
    acc_nxt[WIDTH-1 -: CHUNK] = ss;
  end

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN:  if (last) state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub | c_in;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      acc   <= acc_nxt;
      carry <= cc[CHUNK];
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum   <= acc_nxt;
        c_out <= cc[CHUNK];
        ovf   <= cc[CHUNK-1] ^ cc[CHUNK];
      end
    end
  end
endmodule
